xs_rst_sequencer: RTL and testbench
===================================

# xs_rst_sequencer

Board-level reset sequencer for the FPGA top. Releases PCIe PERST#, waits for DDR calibration, releases device (uncore) reset, then releases CPU and PHY reset on a debounced button release (or automatically). Replaces the ad-hoc cpu_rstn flop and button logic in the top level. It also provides soft re-sequencing from a VIO request and error detection on calibration timeout or loss.

## Interface
Parameters:
- PERST_DLY, 1000: cycles perst_n is held low after reset release (≥1)
- CALIB_TIMEOUT, 5000000: cycles allowed in WAIT_CALIB before ERROR (≥1)
- DEV_DLY, 100: cycles from calibration seen to dev_rstn high (≥1)
- CPU_DLY, 100: cycles from button release to cpu_rstn high (≥1)
- DEBOUNCE_CYC, 50000: stable samples needed to change the debounced button value (≥1)
- AUTO_BOOT, 0: when 1, WAIT_BTN passes through without a button event

Ports:
- sys_clk_i  in  1  sequencer clock (single clock domain)
- sys_rstn  in  1  asynchronous active-low reset
- vio_rst_req  in  1  asynchronous level; high = hold/restart sequence
- btn_cpu_n  in  1  raw asynchronous CPU button, low = pressed
- init_calib_complete  in  1  asynchronous DDR calibration done
- perst_n  out  1  PCIe PERST#, active low
- dev_rstn  out  1  device/uncore reset, active low
- cpu_rstn  out  1  CPU reset, active low
- phy_reset  out  1  GMAC PHY enable, equals cpu_rstn
- seq_state  out  3  current state encoding
- calib_err  out  1  high while in ERROR

## Operation
- vio_rst_req, btn_cpu_n and init_calib_complete each pass through a 2-flop synchronizer. The synchronizer reset values are 0, 1 and 0 respectively.
- Debouncer:
  - The debounced button value resets to 1.
  - It adopts the synchronized value after DEBOUNCE_CYC consecutive equal samples that differ from the current value.
  - rflag: one-cycle pulse on a debounced 0→1 transition.
  - fflag: one-cycle pulse on a debounced 1→0 transition.
- State encodings: PERST_HOLD=0, WAIT_CALIB=1, DEV_WAIT=2, WAIT_BTN=3, CPU_WAIT=4, CPU_RUN=5, ERROR=7.
- A single counter cnt is cleared on every state change.
- State transitions:
  - PERST_HOLD → WAIT_CALIB when cnt==PERST_DLY-1.
  - WAIT_CALIB → DEV_WAIT when synchronized calib is 1; else → ERROR when cnt==CALIB_TIMEOUT-1. Calib wins when both conditions occur in the same cycle.
  - DEV_WAIT → WAIT_BTN when cnt==DEV_DLY-1.
  - WAIT_BTN → CPU_WAIT on rflag, or unconditionally when AUTO_BOOT=1.
  - CPU_WAIT → CPU_RUN when cnt==CPU_DLY-1.
  - CPU_RUN → WAIT_BTN on fflag (button press re-resets the CPU only).
  - ERROR is left only via synchronized vio_rst_req or sys_rstn.
- Calibration loss: synchronized calib falling to 0 in DEV_WAIT, WAIT_BTN, CPU_WAIT or CPU_RUN → ERROR. This has priority over all other transitions except the soft request.
- Soft request: while synchronized vio_rst_req=1, the state is forced to PERST_HOLD with cnt=0. This has the highest priority. Sequencing restarts the cycle after the request drops.
- Output decode (registered; all outputs are decoded from the next-state):
  - perst_n=1 in every state except PERST_HOLD.
  - dev_rstn=1 in WAIT_BTN, CPU_WAIT, CPU_RUN.
  - cpu_rstn=1 only in CPU_RUN.
  - calib_err=1 only in ERROR.
  - In ERROR: perst_n=1, dev_rstn=0, cpu_rstn=0.
- Arithmetic: cnt is unsigned with width CNT_W, sized for the largest delay parameter. It saturates and never wraps.

## Timing
- Reset values: perst_n=0, dev_rstn=0, cpu_rstn=0, phy_reset=0, seq_state=0, calib_err=0, debounced button=1, cnt=0.
- Asynchronous assertion of sys_rstn drives all outputs to reset values immediately, in any state. There are no glitches on deassertion because all flops are reset.
- Relative to the first rising edge after sys_rstn deasserts (edge 1), perst_n rises at edge PERST_DLY.
- Input latencies:
  - Calibration: 2 cycles synchronizer, plus 1 cycle to the state register.
  - Button: 2 synchronizer cycles plus DEBOUNCE_CYC cycles before a flag.
- Reset latencies:
  - cpu_rstn falls 1 cycle after fflag.
  - dev_rstn and cpu_rstn fall 1 cycle after synchronized calib loss.
  - perst_n falls 1 cycle after synchronized vio_rst_req.

## Structure
- Package xs_rst_seq_pkg: state enum (3-bit, encodings above) and the CNT_W helper function (clog2 of max delay + 1).
- Sub-module xs_btn_debounce: synchronizer, debouncer and rflag/fflag generation, parameterized by DEBOUNCE_CYC.
- The top module contains the remaining synchronizers, the FSM, cnt and the output registers.

## Test plan
Common parameters: PERST_DLY=4, CALIB_TIMEOUT=20, DEV_DLY=3, CPU_DLY=2, DEBOUNCE_CYC=3, AUTO_BOOT=0.
- Normal boot:
  - Stimulus: release sys_rstn, raise calib at edge 6, press btn for 6 cycles then release.
  - Response: perst_n↑ at edge 4; dev_rstn↑ 3 cycles after WAIT_CALIB exit; cpu_rstn and phy_reset↑ exactly CPU_DLY+1 cycles after rflag; seq_state ends at 5.
- Calibration timeout:
  - Stimulus: calib never rises.
  - Response: seq_state=7 and calib_err=1 after 20 WAIT_CALIB cycles; dev_rstn=0 and cpu_rstn=0 held; vio_rst_req pulse returns seq_state to 0 with perst_n=0.
- Debounce:
  - Stimulus: button glitches low for 2 cycles.
  - Response: no fflag and cpu_rstn stays 1; a 3-cycle stable press drops cpu_rstn and moves seq_state to 3.
- Calibration loss:
  - Stimulus: calib drops while in CPU_RUN.
  - Response: 3 cycles later (2 sync + 1 state) dev_rstn=0, cpu_rstn=0, seq_state=7.
- Mid-sequence resets:
  - Stimulus: assert sys_rstn low asynchronously during CPU_WAIT; separately raise vio_rst_req during DEV_WAIT.
  - Response: for sys_rstn, all outputs reach reset values before the next clock edge. For vio_rst_req, the sequence restarts from PERST_HOLD after the request drops.
- AUTO_BOOT=1:
  - Stimulus: no button activity.
  - Response: cpu_rstn↑ CPU_DLY+1 cycles after dev_rstn↑.

Source files
------------

// File: rtl/xs_rst_seq_pkg.sv
// xs_rst_seq_pkg: sequencer state encoding and counter width helper.
package xs_rst_seq_pkg;
  typedef enum logic [2:0] {
    PERST_HOLD = 3'd0,
    WAIT_CALIB = 3'd1,
    DEV_WAIT   = 3'd2,
    WAIT_BTN   = 3'd3,
    CPU_WAIT   = 3'd4,
    CPU_RUN    = 3'd5,
    ERROR      = 3'd7
  } seq_state_e;

  function automatic int cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/xs_btn_debounce.sv
// xs_btn_debounce: button synchronizer and debouncer with release/press pulses.
module xs_btn_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_n_i,
  output logic rflag_o,
  output logic fflag_o
);
  localparam int W = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0]   sync_q;
  logic [W-1:0] cnt_q;
  logic         db_q, rflag_q, fflag_q, hit;
  // the count only runs while the synchronized sample disagrees with the debounced value
  assign hit = (sync_q[1] != db_q) && (cnt_q == W'(DEBOUNCE_CYC - 1));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      db_q    <= 1'b1;
      rflag_q <= 1'b0;
      fflag_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      cnt_q   <= (sync_q[1] == db_q || hit) ? '0 : cnt_q + 1'b1;
      db_q    <= hit ? sync_q[1] : db_q;
      rflag_q <= hit & sync_q[1];
      fflag_q <= hit & ~sync_q[1];
    end
  end
  assign rflag_o = rflag_q;
  assign fflag_o = fflag_q;
endmodule

// File: rtl/xs_rst_sequencer.sv
// xs_rst_sequencer: board reset sequencing PERST#, DDR calib, uncore, CPU/PHY.
module xs_rst_sequencer
  import xs_rst_seq_pkg::*;
#(
  parameter int PERST_DLY     = 1000,
  parameter int CALIB_TIMEOUT = 5000000,
  parameter int DEV_DLY       = 100,
  parameter int CPU_DLY       = 100,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int AUTO_BOOT     = 0
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn,
  input  logic       vio_rst_req,
  input  logic       btn_cpu_n,
  input  logic       init_calib_complete,
  output logic       perst_n,
  output logic       dev_rstn,
  output logic       cpu_rstn,
  output logic       phy_reset,
  output logic [2:0] seq_state,
  output logic       calib_err
);
  localparam int CNT_W = cnt_w(PERST_DLY, CALIB_TIMEOUT, DEV_DLY, CPU_DLY);
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       vio_q, cal_q;
  logic             vio_s, cal_s, rflag, fflag;
  logic             perst_q, dev_q, cpu_q, err_q;
  assign vio_s = vio_q[1];
  assign cal_s = cal_q[1];

  xs_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk_i   (sys_clk_i),
    .rst_ni  (sys_rstn),
    .btn_n_i (btn_cpu_n),
    .rflag_o (rflag),
    .fflag_o (fflag)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      PERST_HOLD: state_d = cnt_q == CNT_W'(PERST_DLY - 1) ? WAIT_CALIB : PERST_HOLD;
      WAIT_CALIB: state_d = cal_s ? DEV_WAIT : cnt_q == CNT_W'(CALIB_TIMEOUT - 1) ? ERROR : WAIT_CALIB;
      DEV_WAIT:   state_d = cnt_q == CNT_W'(DEV_DLY - 1) ? WAIT_BTN : DEV_WAIT;
      WAIT_BTN:   state_d = (rflag || AUTO_BOOT != 0) ? CPU_WAIT : WAIT_BTN;
      CPU_WAIT:   state_d = cnt_q == CNT_W'(CPU_DLY - 1) ? CPU_RUN : CPU_WAIT;
      CPU_RUN:    state_d = fflag ? WAIT_BTN : CPU_RUN;
      default:    state_d = state_q;
    endcase
    if (!cal_s && state_q inside {DEV_WAIT, WAIT_BTN, CPU_WAIT, CPU_RUN}) state_d = ERROR;
    if (vio_s) state_d = PERST_HOLD;
    cnt_d = (vio_s || state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn) begin
    if (!sys_rstn) begin
      vio_q   <= 2'b00;
      cal_q   <= 2'b00;
      state_q <= PERST_HOLD;
      cnt_q   <= '0;
      perst_q <= 1'b0;
      dev_q   <= 1'b0;
      cpu_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vio_q   <= {vio_q[0], vio_rst_req};
      cal_q   <= {cal_q[0], init_calib_complete};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perst_q <= state_d != PERST_HOLD;
      dev_q   <= state_d inside {WAIT_BTN, CPU_WAIT, CPU_RUN};
      cpu_q   <= state_d == CPU_RUN;
      err_q   <= state_d == ERROR;
    end
  end

  assign perst_n   = perst_q;
  assign dev_rstn  = dev_q;
  assign cpu_rstn  = cpu_q;
  assign phy_reset = cpu_q;
  assign seq_state = state_q;
  assign calib_err = err_q;
endmodule

// File: tb/tb_xs_rst_sequencer.sv
// tb_xs_rst_sequencer: random stimulus on manual and auto-boot sequencers against a phase-timing model.
module tb_xs_rst_sequencer;
  localparam int PD = 4, CT = 20, DD = 3, CD = 2, DEB = 3;
  logic clk = 0, rst_n = 0, vio = 0, cal = 0, btn = 1;
  logic p[2], d[2], c[2], y[2], e[2];
  logic [2:0] s[2];
  int n_chk = 0, n_err = 0;
  int vh[2], ch[2], bh[2], bhist[DEB];
  int db, rf, ff;
  int st[2], t[2];

  always #5 clk = ~clk;

  xs_rst_sequencer #(.PERST_DLY(PD), .CALIB_TIMEOUT(CT), .DEV_DLY(DD), .CPU_DLY(CD),
                     .DEBOUNCE_CYC(DEB), .AUTO_BOOT(0)) u0 (
    .sys_clk_i(clk), .sys_rstn(rst_n), .vio_rst_req(vio), .btn_cpu_n(btn),
    .init_calib_complete(cal), .perst_n(p[0]), .dev_rstn(d[0]), .cpu_rstn(c[0]),
    .phy_reset(y[0]), .seq_state(s[0]), .calib_err(e[0]));

  xs_rst_sequencer #(.PERST_DLY(PD), .CALIB_TIMEOUT(CT), .DEV_DLY(DD), .CPU_DLY(CD),
                     .DEBOUNCE_CYC(DEB), .AUTO_BOOT(1)) u1 (
    .sys_clk_i(clk), .sys_rstn(rst_n), .vio_rst_req(vio), .btn_cpu_n(btn),
    .init_calib_complete(cal), .perst_n(p[1]), .dev_rstn(d[1]), .cpu_rstn(c[1]),
    .phy_reset(y[1]), .seq_state(s[1]), .calib_err(e[1]));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] obs(input int k);
    return {p[k], d[k], c[k], y[k], s[k], e[k]};
  endfunction

  function automatic logic [7:0] pred(input int k);
    logic [2:0] s3;
    s3 = 3'(st[k]);
    return {st[k] != 0, st[k] >= 3 && st[k] <= 5, st[k] == 5, st[k] == 5, s3, st[k] == 7};
  endfunction

  function automatic int dur(input int sv);
    return sv == 0 ? PD : sv == 1 ? CT : sv == 2 ? DD : sv == 4 ? CD : 0;
  endfunction

  task automatic model_reset();
    vh = '{0, 0}; ch = '{0, 0}; bh = '{1, 1};
    for (int i = 0; i < DEB; i++) bhist[i] = 1;
    db = 1; rf = 0; ff = 0;
    st = '{0, 0}; t = '{0, 0};
  endtask

  task automatic model_step(input int vi, input int ci, input int bi);
    int vs, cs, bs, n, all;
    vs = vh[1]; cs = ch[1]; bs = bh[1];
    for (int k = 0; k < 2; k++) begin
      n = st[k];
      if (vs) n = 0;
      else if (st[k] >= 2 && st[k] <= 5 && !cs) n = 7;
      else if (st[k] == 1 && cs) n = 2;
      else if (st[k] == 3) n = (rf != 0 || k == 1) ? 4 : 3;
      else if (st[k] == 5) n = ff != 0 ? 3 : 5;
      else if (dur(st[k]) > 0 && t[k] + 1 >= dur(st[k])) n = st[k] == 1 ? 7 : st[k] + 1;
      t[k] = (n != st[k] || vs != 0) ? 0 : t[k] + 1;
      st[k] = n;
    end
    for (int i = DEB - 1; i > 0; i--) bhist[i] = bhist[i-1];
    bhist[0] = bs;
    all = 1;
    for (int i = 0; i < DEB; i++) if (bhist[i] == db) all = 0;
    rf = all != 0 && bs == 1;
    ff = all != 0 && bs == 0;
    if (all != 0) db = bs;
    vh[1] = vh[0]; vh[0] = vi;
    ch[1] = ch[0]; ch[0] = ci;
    bh[1] = bh[0]; bh[0] = bi;
  endtask

  initial begin
    int vio_left, btn_hold;
    vio_left = 0; btn_hold = 8;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_u0", obs(0), 8'h00);
    chk("rst_u1", obs(1), 8'h00);
    rst_n = 1;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (vio_left > 0) vio_left--;
      else if ($urandom_range(0, 299) == 0) vio_left = $urandom_range(1, 3);
      vio = vio_left > 0;
      if (!cal) cal = $urandom_range(0, 7) == 0;
      else if ($urandom_range(0, 199) == 0) cal = 0;
      if (btn_hold == 0) begin
        btn = ~btn;
        btn_hold = $urandom_range(0, 9);
      end else btn_hold--;
      model_step(int'(vio), int'(cal), int'(btn));
      @(negedge clk);
      chk("seq_u0", obs(0), pred(0));
      chk("seq_u1", obs(1), pred(1));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 0;
        #1;
        chk("arst_u0", obs(0), 8'h00);
        chk("arst_u1", obs(1), 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
